riscv_core_ctrl: RTL and testbench

- Parametrised run-control and boot shell for the pipelined RISC-V core; sits between the SoC top and the pipeline.
- Streams a program image into instruction memory and holds the core in reset for a programmable number of cycles.
- Provides run, halt, resume and single-step control through a pipeline enable.
- Maintains cycle and retired-instruction counters.

---
 rtl/riscv_core_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_riscv_core_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_ctrl.sv
// Run-control and boot shell for the pipelined RISC-V core: streams the program
// image into IMEM, holds the core in reset, then runs/halts/steps it.
// Optional watchdog: define RISCV_CTRL_WATCHDOG_EN.
module riscv_core_ctrl #(
  parameter int XLEN       = 32,
  parameter int IMEM_AW    = 10,
  parameter int RST_HOLD   = 4,
  parameter int CNT_W      = 32,
  parameter int WDT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [XLEN-1:0]    load_data,
  input  logic               load_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               core_rst,
  output logic               core_en,
  input  logic               core_retire,
  input  logic               halt_req,
  input  logic               resume_req,
  input  logic               step_req,
  output logic               halted,
  output logic               running,
  output logic               load_err,
  output logic               wdt_fired,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [IMEM_AW-1:0] PTR_MAX = {IMEM_AW{1'b1}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  if (RST_HOLD < 1 || WDT_CYCLES < 1) begin : g_bad_cfg
    $error("riscv_core_ctrl: RST_HOLD and WDT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3,
    ST_STEP = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
  logic               core_rst_q, core_rst_d;
  logic               core_en_q, core_en_d;
  logic               halted_q, halted_d;
  logic               running_q, running_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   instret_cnt_q, instret_cnt_d;
  logic               accept_s;
  logic               wdt_hit_s;
  logic               wdt_fired_d;

`ifdef RISCV_CTRL_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_fired_q;

  // Watchdog counter: counts consecutive non-retiring RUN cycles, idle at zero elsewhere.
  always_comb begin
    wdt_cnt_d = '0;
    wdt_hit_s = 1'b0;
    if (state_q == ST_RUN && !core_retire) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      wdt_hit_s = (wdt_cnt_q == WDT_LAST);
    end else begin
      wdt_cnt_d = '0;
      wdt_hit_s = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  assign wdt_hit_s = 1'b0;
  assign wdt_fired = 1'b0;
`endif

  assign accept_s   = load_valid & load_ready;
  assign load_ready = (state_q == ST_LOAD) & ~rst;

  // Next-state, boot write path and counters.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    load_err_d    = load_err_q;
    wdt_fired_d   = wdt_fired;
    cycle_cnt_d   = core_en_q ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
    instret_cnt_d = (core_en_q && core_retire) ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = load_data;
          // The pointer saturates at the top word; an unterminated image there is an overflow.
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + IMEM_AW'(1);
          end else begin
            ptr_d = ptr_q;
          end
          if (load_last) begin
            state_d = ST_HOLD;
          end else if (ptr_q == PTR_MAX) begin
            load_err_d = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (halt_req || wdt_hit_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
        if (wdt_hit_s) begin
          wdt_fired_d = 1'b1;
        end else begin
          wdt_fired_d = wdt_fired;
        end
      end
      ST_HALT: begin
        if (resume_req) begin
          state_d     = ST_RUN;
          wdt_fired_d = 1'b0;
        end else if (step_req) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (core_retire) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    // Entering HOLD starts a fresh run: hold timer and performance counters restart.
    if (state_d == ST_HOLD && state_q != ST_HOLD) begin
      hold_cnt_d    = '0;
      cycle_cnt_d   = '0;
      instret_cnt_d = '0;
    end else begin
      hold_cnt_d    = hold_cnt_d;
    end

    core_rst_d = (state_d == ST_LOAD) || (state_d == ST_HOLD);
    core_en_d  = (state_d == ST_RUN) || (state_d == ST_STEP);
    running_d  = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      core_rst_q    <= 1'b1;
      core_en_q     <= 1'b0;
      halted_q      <= 1'b0;
      running_q     <= 1'b0;
      load_err_q    <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_rst_q    <= core_rst_d;
      core_en_q     <= core_en_d;
      halted_q      <= halted_d;
      running_q     <= running_d;
      load_err_q    <= load_err_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign core_rst    = core_rst_q;
  assign core_en     = core_en_q;
  assign halted      = halted_q;
  assign running     = running_q;
  assign load_err    = load_err_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_riscv_core_ctrl.sv
// Bench for riscv_core_ctrl: directed boot/overflow/halt/step/reset sequences,
// IMEM writes checked by a scoreboard monitor, status outputs checked inline.
module tb_riscv_core_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 2;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [XLEN-1:0] load_data = '0;
  logic            load_last = 1'b0;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;
  logic            core_rst;
  logic            core_en;
  logic            core_retire = 1'b0;
  logic            halt_req = 1'b0;
  logic            resume_req = 1'b0;
  logic            step_req = 1'b0;
  logic            halted;
  logic            running;
  logic            load_err;
  logic            wdt_fired;
  logic [CW-1:0]   cycle_cnt;
  logic [CW-1:0]   instret_cnt;

  int total = 0;
  int bad   = 0;
  logic [AW+XLEN-1:0] wq[$];

  always #5 clk = ~clk;

  riscv_core_ctrl #(
    .XLEN(XLEN), .IMEM_AW(AW), .RST_HOLD(4), .CNT_W(CW), .WDT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_en(core_en), .core_retire(core_retire),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .halted(halted), .running(running), .load_err(load_err), .wdt_fired(wdt_fired),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every IMEM write must match the oldest accepted beat.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL imem_write: unexpected write addr=%0h data=%0h", imem_addr, imem_wdata);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = wq.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          bad++;
          $display("FAIL imem_write: got addr=%0h data=%0h want addr=%0h data=%0h",
                   imem_addr, imem_wdata, e[AW+XLEN-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  // Called at a negedge; the beat is presented for the following posedge.
  task automatic beat(input logic [XLEN-1:0] d, input logic l, input logic exp_acc, input logic [AW-1:0] a);
    chk("load_ready", load_ready, exp_acc);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = l;
    if (exp_acc) wq.push_back({a, d});
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", imem_addr, '0);
    chk("rst_imem_wdata", imem_wdata, '0);
    chk("rst_core_en", core_en, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_wdt_fired", wdt_fired, 1'b0);
    chk("rst_cycle_cnt", cycle_cnt, '0);
    chk("rst_instret_cnt", instret_cnt, '0);
  endtask

  task automatic hold_then_run(input int n_hold);
    for (int i = 0; i < n_hold; i++) begin
      chk("hold_core_rst", core_rst, 1'b1);
      chk("hold_core_en", core_en, 1'b0);
      @(negedge clk);
    end
    chk("run_core_rst", core_rst, 1'b0);
    chk("run_running", running, 1'b1);
    chk("run_core_en", core_en, 1'b1);
    chk("run_cycle_cnt0", cycle_cnt, '0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);

    // Boot load of three words.
    beat(32'h0000_0013, 1'b0, 1'b1, 2'd0);
    beat(32'h0010_0093, 1'b0, 1'b1, 2'd1);
    beat(32'h0000_0073, 1'b1, 1'b1, 2'd2);
    chk("hold_load_ready", load_ready, 1'b0);
    hold_then_run(4);

    // RUN: two retirements, then halt and resume together (halt wins).
    core_retire = 1'b1;
    @(negedge clk);
    chk("run_cycle_cnt1", cycle_cnt, 32'd1);
    @(negedge clk);
    chk("run_instret2", instret_cnt, 32'd2);
    core_retire = 1'b0;
    halt_req    = 1'b1;
    resume_req  = 1'b1;
    @(negedge clk);
    chk("halt_core_en", core_en, 1'b0);
    chk("halt_halted", halted, 1'b1);
    chk("halt_running", running, 1'b0);
    chk("halt_cycle_cnt", cycle_cnt, 32'd3);
    halt_req    = 1'b0;
    resume_req  = 1'b0;
    core_retire = 1'b1;
    @(negedge clk);
    chk("halt_retire_ignored", instret_cnt, 32'd2);
    core_retire = 1'b0;
    step_req    = 1'b1;

    // Single step: retire arrives on the fourth STEP cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step_req = 1'b0;
      chk("step_core_en", core_en, 1'b1);
      chk("step_halted", halted, 1'b0);
      halt_req = (i >= 1);
      core_retire = (i == 3);
    end
    @(negedge clk);
    core_retire = 1'b0;
    halt_req    = 1'b0;
    chk("step_back_halted", halted, 1'b1);
    chk("step_core_en_off", core_en, 1'b0);
    chk("step_instret", instret_cnt, 32'd3);
    chk("step_cycle_cnt", cycle_cnt, 32'd7);

    // HALT: resume and step together -> RUN.
    resume_req = 1'b1;
    step_req   = 1'b1;
    @(negedge clk);
    resume_req = 1'b0;
    step_req   = 1'b0;
    chk("prio_running", running, 1'b1);
    chk("prio_core_en", core_en, 1'b1);
    chk("prio_cycle_cnt", cycle_cnt, 32'd7);

`ifdef RISCV_CTRL_WATCHDOG_EN
    // Sixteen RUN cycles without retirement trip the watchdog.
    for (int i = 0; i < 16; i++) begin
      chk("wdt_quiet", wdt_fired, 1'b0);
      @(negedge clk);
    end
    chk("wdt_fired", wdt_fired, 1'b1);
    chk("wdt_halted", halted, 1'b1);
    resume_req = 1'b1;
    @(negedge clk);
    resume_req = 1'b0;
    chk("wdt_cleared", wdt_fired, 1'b0);
    chk("wdt_resumed", running, 1'b1);
`else
    repeat (20) @(negedge clk);
    chk("no_wdt_fired", wdt_fired, 1'b0);
    chk("no_wdt_running", running, 1'b1);
`endif

    // Overflow: four words fill IMEM, the fifth is refused.
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    beat(32'hA000_0000, 1'b0, 1'b1, 2'd0);
    beat(32'hA000_0001, 1'b0, 1'b1, 2'd1);
    beat(32'hA000_0002, 1'b0, 1'b1, 2'd2);
    chk("ovf_no_err_yet", load_err, 1'b0);
    beat(32'hA000_0003, 1'b0, 1'b1, 2'd3);
    chk("ovf_load_err", load_err, 1'b1);
    beat(32'hA000_0004, 1'b0, 1'b0, 2'd0);
    hold_then_run(3);
    chk("ovf_err_sticky", load_err, 1'b1);

    // Reset in the middle of a load, then a clean reload from address 0.
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    beat(32'hB000_0000, 1'b0, 1'b1, 2'd0);
    beat(32'hB000_0001, 1'b0, 1'b1, 2'd1);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'hB000_0002;
    @(negedge clk);
    chk_reset();
    rst        = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    beat(32'hC000_0000, 1'b0, 1'b1, 2'd0);
    beat(32'hC000_0001, 1'b0, 1'b1, 2'd1);
    beat(32'hC000_0002, 1'b1, 1'b1, 2'd2);
    hold_then_run(4);
    @(negedge clk);

    chk("scoreboard_drained", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
